// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO output arbiter.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } gpio_arb_state_t;

    localparam logic [31:0] GPIO_ARB_IDLE_VALUE = '0;

    // Round-robin pointer advance; works for any requester count, not just powers of 2.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gpio_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above rrPtr_i, wrapping.
module gpio_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    rrPtr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               anyValid_o
);

    logic [2*NUM_REQ-1:0] searchVec;
    logic                 found;

    // The lower copy is masked below the pointer; the upper copy supplies the wrapped tail.
    always_comb begin
        searchVec = {valid_i, valid_i};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i < int'(rrPtr_i)) begin
                searchVec[i] = 1'b0;
            end
        end
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            if (!found && searchVec[i]) begin
                found                = 1'b1;
                idx_o                = ID_W'(i % NUM_REQ);
                grant_o[i % NUM_REQ] = 1'b1;
            end
        end
    end

    assign anyValid_o = |valid_i;

endmodule

// File: rtl/gpio_out_arbiter.sv
// Round-robin arbiter sharing one GPIO output bus; each winner drives its value for its hold
// time, followed by a one-cycle turnaround.
module gpio_out_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int               NUM_REQ    = 4,
    parameter int               WIDTH      = 32,
    parameter int               HOLD_W     = 8,
    parameter logic [WIDTH-1:0] IDLE_VALUE = WIDTH'(GPIO_ARB_IDLE_VALUE),
    localparam int              ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data_i,
    input  logic [NUM_REQ*HOLD_W-1:0] req_hold_i,
    output logic [WIDTH-1:0]          gpio_pin_o,
    output logic                      gpio_oe_o,
    output logic [ID_W-1:0]           grant_id_o,
    output logic                      busy_o,
    output logic                      done_o
);

    gpio_arb_state_t    state_q;
    logic [ID_W-1:0]    rrPtr_q;
    logic [ID_W-1:0]    rrPtr_d;
    logic [ID_W-1:0]    grantId_q;
    logic [HOLD_W-1:0]  cnt_q;
    logic [HOLD_W-1:0]  cnt_d;
    logic [WIDTH-1:0]   pin_q;
    logic               oe_q;
    logic               done_q;

    logic [NUM_REQ-1:0] pickOneHot;
    logic [ID_W-1:0]    pickIdx;
    logic               anyValid;
    logic [WIDTH-1:0]   dataSel;
    logic [HOLD_W-1:0]  holdSel;
    logic               handshake;

    gpio_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid_i    (req_valid_i),
        .rrPtr_i    (rrPtr_q),
        .grant_o    (pickOneHot),
        .idx_o      (pickIdx),
        .anyValid_o (anyValid)
    );

    assign dataSel     = req_data_i[int'(pickIdx)*WIDTH +: WIDTH];
    assign holdSel     = req_hold_i[int'(pickIdx)*HOLD_W +: HOLD_W];
    assign cnt_d       = (holdSel == '0) ? HOLD_W'(1) : holdSel;
    assign rrPtr_d     = ID_W'(wrapInc(int'(pickIdx), NUM_REQ));
    assign handshake   = (state_q == IDLE) && anyValid;
    assign req_ready_o = (state_q == IDLE) ? pickOneHot : '0;

    // done_q is raised one edge early so it coincides with the final drive cycle (cnt_q == 1).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grantId_q <= '0;
            cnt_q     <= '0;
            pin_q     <= IDLE_VALUE;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q   <= DRIVE;
                        pin_q     <= dataSel;
                        oe_q      <= 1'b1;
                        cnt_q     <= cnt_d;
                        done_q    <= (cnt_d == HOLD_W'(1));
                        grantId_q <= pickIdx;
                        rrPtr_q   <= rrPtr_d;
                    end
                end
                DRIVE: begin
                    if (cnt_q == HOLD_W'(1)) begin
                        state_q <= GAP;
                        pin_q   <= IDLE_VALUE;
                        oe_q    <= 1'b0;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q  <= cnt_q - HOLD_W'(1);
                        done_q <= (cnt_q == HOLD_W'(2));
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gpio_pin_o = pin_q;
    assign gpio_oe_o  = oe_q;
    assign done_o     = done_q;
    assign grant_id_o = grantId_q;
    assign busy_o     = (state_q != IDLE);

    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
    assert property (@(posedge clk_i) disable iff (rst_i) gpio_oe_o |-> (state_q == DRIVE));
    assert property (@(posedge clk_i) disable iff (rst_i) done_o |-> gpio_oe_o);

endmodule

// File: tb/tb_gpio_out_arbiter.sv
// Directed self-checking bench for gpio_out_arbiter with hand-computed expectations.
module tb_gpio_out_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int HOLD_W  = 8;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ-1:0]        reqReady;
    logic [NUM_REQ*WIDTH-1:0]  reqData;
    logic [NUM_REQ*HOLD_W-1:0] reqHold;
    logic [WIDTH-1:0]          gpioPin;
    logic                      gpioOe;
    logic [1:0]                grantId;
    logic                      busy;
    logic                      done;

    int checkCount = 0;
    int errorCount = 0;

    gpio_out_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_data_i  (reqData),
        .req_hold_i  (reqHold),
        .gpio_pin_o  (gpioPin),
        .gpio_oe_o   (gpioOe),
        .grant_id_o  (grantId),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
        reqValid = valid;
        #1;
    endtask

    task automatic setReq(input int k, input logic [WIDTH-1:0] data, input logic [HOLD_W-1:0] hold);
        reqData[k*WIDTH +: WIDTH]   = data;
        reqHold[k*HOLD_W +: HOLD_W] = hold;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        reqValid = '0;
        rst      = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        #1;
    endtask

    logic [31:0] seqData [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    int oeCycles;
    int doneCount;
    int doneAt;

    initial begin
        rst      = 1'b1;
        reqValid = '0;
        reqData  = '0;
        reqHold  = '0;

        // Reset idle state over ten cycles.
        stepCycle();
        stepCycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("rst_idle", {gpioPin[27:0], gpioOe, busy, done, |reqReady}, 32'h0);
        end
        checkOutput("rst_grant", {30'b0, grantId}, 32'h0);

        // Single request, hold 3.
        setReq(0, 32'hA5A5_0001, 8'd3);
        applyStimulus(4'b0001);
        checkOutput("t2_ready", {28'b0, reqReady}, 32'h1);
        stepCycle();
        applyStimulus(4'b0000);
        checkOutput("t2_pin1", gpioPin, 32'hA5A5_0001);
        checkOutput("t2_oe1_done", {30'b0, gpioOe, done}, 32'h2);
        stepCycle();
        checkOutput("t2_oe2_done", {30'b0, gpioOe, done}, 32'h2);
        stepCycle();
        checkOutput("t2_oe3_done", {30'b0, gpioOe, done}, 32'h3);
        checkOutput("t2_pin3", gpioPin, 32'hA5A5_0001);
        stepCycle();
        checkOutput("t2_gap", {29'b0, gpioOe, busy, done}, 32'h2);
        checkOutput("t2_gap_pin", gpioPin, 32'h0);
        stepCycle();
        checkOutput("t2_idle_busy", {31'b0, busy}, 32'h0);

        // Strict rotation with every requester valid and hold 1.
        doReset();
        for (int k = 0; k < NUM_REQ; k++) setReq(k, seqData[k], 8'd1);
        applyStimulus(4'b1111);
        for (int n = 0; n < 6; n++) begin
            checkOutput("t3_ready", {28'b0, reqReady}, 32'h1 << (n % 4));
            stepCycle();
            checkOutput("t3_grant", {30'b0, grantId}, n % 4);
            checkOutput("t3_pin", gpioPin, seqData[n % 4]);
            checkOutput("t3_done", {31'b0, done}, 32'h1);
            stepCycle();
            stepCycle();
        end
        applyStimulus(4'b0000);

        // Hold 0 behaves as 1, then hold 255 from the wrapped pointer.
        doReset();
        setReq(2, 32'hC0DE_0002, 8'd0);
        applyStimulus(4'b0100);
        checkOutput("t4_ready0", {28'b0, reqReady}, 32'h4);
        stepCycle();
        applyStimulus(4'b0000);
        checkOutput("t4_h0_drive", {29'b0, gpioOe, done, busy}, 32'h7);
        checkOutput("t4_h0_grant", {30'b0, grantId}, 32'h2);
        stepCycle();
        checkOutput("t4_h0_gap", {30'b0, gpioOe, done}, 32'h0);
        stepCycle();
        setReq(2, 32'hBEEF_00FF, 8'd255);
        applyStimulus(4'b0100);
        checkOutput("t4_ready255", {28'b0, reqReady}, 32'h4);
        oeCycles  = 0;
        doneCount = 0;
        doneAt    = 0;
        for (int i = 0; i < 300; i++) begin
            stepCycle();
            if (i == 0) applyStimulus(4'b0000);
            if (gpioOe) oeCycles++;
            if (done) begin
                doneCount++;
                doneAt = oeCycles;
            end
        end
        checkOutput("t4_h255_cycles", oeCycles, 32'd255);
        checkOutput("t4_h255_done_count", doneCount, 32'd1);
        checkOutput("t4_h255_done_at", doneAt, 32'd255);

        // Reset during a hold-10 drive from req2.
        doReset();
        setReq(2, 32'h5555_AAAA, 8'd10);
        setReq(1, 32'h0000_0101, 8'd1);
        setReq(3, 32'h0000_0303, 8'd1);
        applyStimulus(4'b0100);
        stepCycle();
        applyStimulus(4'b0000);
        repeat (4) stepCycle();
        checkOutput("t5_pre_oe", {31'b0, gpioOe}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_out", {28'b0, gpioOe, busy, done, |grantId}, 32'h0);
        checkOutput("t5_rst_pin", gpioPin, 32'h0);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (done || gpioOe) doneCount++;
        end
        checkOutput("t5_no_done", doneCount, 32'd0);
        applyStimulus(4'b1010);
        checkOutput("t5_ready", {28'b0, reqReady}, 32'h2);
        stepCycle();
        applyStimulus(4'b0000);
        checkOutput("t5_grant", {30'b0, grantId}, 32'h1);
        checkOutput("t5_pin", gpioPin, 32'h0000_0101);

        // Request arriving during DRIVE waits; pointer wraps after req3.
        doReset();
        setReq(3, 32'h3333_3333, 8'd4);
        setReq(1, 32'h1111_1111, 8'd1);
        applyStimulus(4'b1000);
        checkOutput("t6_ready3", {28'b0, reqReady}, 32'h8);
        stepCycle();
        applyStimulus(4'b0010);
        checkOutput("t6_drive_ready", {28'b0, reqReady}, 32'h0);
        checkOutput("t6_grant3", {30'b0, grantId}, 32'h3);
        repeat (3) stepCycle();
        checkOutput("t6_done", {30'b0, done, |reqReady}, 32'h2);
        stepCycle();
        checkOutput("t6_gap", {29'b0, gpioOe, busy, |reqReady}, 32'h2);
        stepCycle();
        checkOutput("t6_ready1", {28'b0, reqReady}, 32'h2);
        stepCycle();
        applyStimulus(4'b0000);
        checkOutput("t6_grant1", {30'b0, grantId}, 32'h1);
        checkOutput("t6_pin1", gpioPin, 32'h1111_1111);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
